// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and helper definitions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_NAND = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit logic / add / sub / set-less-than unit.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    logic             is_add;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH:0]   sum;
    logic             sum_ovf;

    // SUB and SLT share the adder as a + ~b + 1.
    assign is_add  = (op == OP_ADD);
    assign b_eff   = is_add ? b : ~b;
    assign c_eff   = is_add ? cin : 1'b1;
    assign sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    assign sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result   = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_ADD, OP_SUB: begin
                result   = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = sum_ovf;
            end
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_ovf};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: handshake FSM, iterative shifter / shift-add multiplier, registered flags.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic               accept, legal, iter_start, last, load_out;
    logic [SHW-1:0]     shamt;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   sh_q, sh_nxt;
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_nxt;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   core_res;
    logic               core_cout, core_ovf;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_cout, fin_ovf, fin_zero, fin_neg, fin_err;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op       (alu_op),
        .result   (core_res),
        .cout     (core_cout),
        .overflow (core_ovf)
    );

    assign shamt      = b[SHW-1:0];
    assign in_ready   = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid  = (state == S_DONE);
    assign accept     = in_valid && in_ready;
    assign legal      = (alu_op <= OP_MUL) && ((alu_op != OP_MUL) || ENABLE_MUL);
    assign iter_start = legal && is_iterative(alu_op) && ((alu_op == OP_MUL) || (shamt != '0));
    assign last       = (state == S_EXEC) && (cnt_q == CW'(1));
    assign load_out   = last || (accept && !iter_start);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = iter_start ? S_EXEC : S_DONE;
            S_EXEC: if (cnt_q == CW'(1)) state_nxt = S_DONE;
            S_DONE: begin
                if (accept)         state_nxt = iter_start ? S_EXEC : S_DONE;
                else if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One iteration step: shifts move one bit; MUL conditionally adds the multiplicand.
    always_comb begin
        case (op_q)
            OP_SLL:  sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
            OP_SRA:  sh_nxt = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            default: sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
        endcase
        acc_nxt = acc_q + (sh_q[0] ? mcand_q : '0);
    end

    always_comb begin
        fin_res  = '0;
        fin_cout = 1'b0;
        fin_ovf  = 1'b0;
        fin_err  = 1'b0;
        if (state == S_EXEC) begin
            if (op_q == OP_MUL) begin
                fin_res = acc_nxt[WIDTH-1:0];
                fin_ovf = |acc_nxt[2*WIDTH-1:WIDTH];
            end else begin
                fin_res = sh_nxt;
            end
        end else if (!legal) begin
            fin_err = 1'b1;
        end else if (is_iterative(alu_op)) begin
            fin_res = a;
        end else begin
            fin_res  = core_res;
            fin_cout = core_cout;
            fin_ovf  = core_ovf;
        end
        fin_zero = !fin_err && (fin_res == '0);
        fin_neg  = fin_res[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept && iter_start)
                cnt_q <= (alu_op == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
            else if (state == S_EXEC)
                cnt_q <= cnt_q - CW'(1);
            if (load_out) begin
                result   <= fin_res;
                cout     <= fin_cout;
                overflow <= fin_ovf;
                zero     <= fin_zero;
                negative <= fin_neg;
                err      <= fin_err;
            end
        end
    end

    // Operand / accumulator registers carry no reset; the FSM qualifies their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= alu_op;
            sh_q    <= (alu_op == OP_MUL) ? b : a;
            mcand_q <= {{WIDTH{1'b0}}, a};
            acc_q   <= '0;
        end else if (state == S_EXEC) begin
            sh_q    <= sh_nxt;
            mcand_q <= mcand_q << 1;
            acc_q   <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized bench for alu_multicycle (WIDTH=8) against an arithmetic reference model.
module tb_alu_multicycle;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [3:0]   alu_op;
    logic         cout, overflow, zero, negative, err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       cout, ovf, zero, neg, err;
        logic [7:0] lat;
    } exp_t;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W), .ENABLE_MUL(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int op, input int av, input int bv, input int ci);
        exp_t e;
        int sa, sb, sh, s, t;
        sa = (av >= 128) ? av - 256 : av;
        sb = (bv >= 128) ? bv - 256 : bv;
        sh = bv % 8;
        e = '0;
        e.lat = 8'd1;
        s = 0;
        case (op)
            0:  s = av & bv;
            1:  s = av | bv;
            2:  begin s = av + bv + ci; t = sa + sb + ci; e.cout = s[8]; e.ovf = (t > 127) || (t < -128); end
            3:  s = av ^ bv;
            4:  s = ~(av & bv);
            5:  s = ~(av | bv);
            6:  begin s = av + (255 - bv) + 1; t = sa - sb; e.cout = s[8]; e.ovf = (t > 127) || (t < -128); end
            7:  s = (sa < sb) ? 1 : 0;
            8:  begin s = av << sh; e.lat = 8'(1 + sh); end
            9:  begin s = av >> sh; e.lat = 8'(1 + sh); end
            10: begin s = sa >>> sh; e.lat = 8'(1 + sh); end
            11: begin s = av * bv; e.ovf = (s >> 8) != 0; e.lat = 8'd9; end
            default: e.err = 1'b1;
        endcase
        if (!e.err) begin
            e.res  = s[7:0];
            e.zero = (s[7:0] == 8'h00);
            e.neg  = s[7];
        end
        return e;
    endfunction

    task automatic present(input int op, input int av, input int bv, input int ci);
        alu_op   = op[3:0];
        a        = av[7:0];
        b        = bv[7:0];
        cin      = ci[0];
        in_valid = 1'b1;
    endtask

    task automatic wait_valid(input exp_t e, input string tag);
        int n = 0;
        while (!out_valid && n < 40) begin
            chk({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n + 1, {24'd0, e.lat});
        chk({tag, "_result"}, {24'd0, result}, {24'd0, e.res});
        chk({tag, "_flags"}, {27'd0, cout, overflow, zero, negative, err},
            {27'd0, e.cout, e.ovf, e.zero, e.neg, e.err});
    endtask

    // Issue one op from IDLE, wait for it, optionally stall the consumer, then drain.
    task automatic run_op(input int op, input int av, input int bv, input int ci, input int hold, input string tag);
        exp_t e;
        e = model(op, av, bv, ci);
        out_ready = 1'b0;
        present(op, av, bv, ci);
        #1;
        chk({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); alu_op = 4'($urandom); cin = 1'($urandom);
        wait_valid(e, tag);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "_hold_result"}, {24'd0, result}, {24'd0, e.res});
            chk({tag, "_hold_flags"}, {27'd0, cout, overflow, zero, negative, err},
                {27'd0, e.cout, e.ovf, e.zero, e.neg, e.err});
        end
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;
        int   seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; alu_op = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_result", {24'd0, result}, 32'd0);
        chk("reset_flags", {27'd0, cout, overflow, zero, negative, err}, 32'd0);

        run_op(2, 'hFF, 'h01, 0, 0, "add_wrap");
        run_op(6, 'h80, 'h01, 0, 0, "sub_ovf");
        run_op(7, 'hFE, 'h01, 0, 0, "slt_neg");
        run_op(7, 'h01, 'hFE, 0, 0, "slt_pos");
        run_op(10, 'h90, 'h03, 0, 0, "sra3");
        run_op(9, 'h90, 'h03, 0, 0, "srl3");
        run_op(8, 'h90, 'h00, 0, 0, "sll0");
        run_op(8, 'h81, 'h07, 0, 1, "sll7");
        run_op(11, 'h10, 'h11, 0, 5, "mul_stall");
        run_op(12, 'h55, 'hAA, 1, 0, "illegal_c");
        run_op(15, 'h00, 'h00, 0, 0, "illegal_f");

        // Back-to-back: new op accepted in the same cycle as the result transfer.
        e1 = model(2, 'h12, 'h34, 1);
        e2 = model(3, 'hF0, 'h3C, 0);
        present(2, 'h12, 'h34, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(e1, "b2b_first");
        present(3, 'hF0, 'h3C, 0);
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_no_bubble", {31'd0, out_valid}, 32'd1);
        chk("b2b_second_result", {24'd0, result}, {24'd0, e2.res});
        chk("b2b_second_flags", {27'd0, cout, overflow, zero, negative, err},
            {27'd0, e2.cout, e2.ovf, e2.zero, e2.neg, e2.err});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during a multiply aborts it without ever presenting a result.
        present(11, 'hFF, 'hFF, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mul_busy", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mul_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mul_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mul_result", {24'd0, result}, 32'd0);
        chk("rst_mul_flags", {27'd0, cout, overflow, zero, negative, err}, 32'd0);
        seen = 0;
        out_ready = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("rst_mul_no_stale", seen, 0);

        // Reset wins over a simultaneous accept.
        rst = 1'b1;
        present(2, 'h01, 'h01, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_priority", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 150; i++) begin
            run_op($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 1), $urandom_range(0, 2), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
